// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one-entry instruction buffer fed by a single-outstanding memory read.
// Define FETCH_PREFETCH_EN to fetch pc+1 automatically after every accepted instruction.
module instr_fetch_unit #(
   parameter int ADDR_WIDTH  = 4,
   parameter int INSTR_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_WIDTH-1:0]  pc,
   input  logic                   fetch_req,
   output logic                   instr_valid,
   output logic [INSTR_WIDTH-1:0] next_instr,
   output logic                   mem_rd_en,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic                   mem_rd_valid,
   input  logic [INSTR_WIDTH-1:0] mem_rd_data
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t                 state_reg;
   logic                   buf_valid_reg;
   logic [ADDR_WIDTH-1:0]  buf_addr_reg;
   logic [INSTR_WIDTH-1:0] buf_data_reg;
   logic [ADDR_WIDTH-1:0]  pend_addr_reg;
   logic                   mem_rd_en_reg;
   logic [ADDR_WIDTH-1:0]  mem_addr_reg;
   logic                   hit;

   assign hit         = buf_valid_reg && (buf_addr_reg == pc);
   assign instr_valid = fetch_req && hit;
   assign next_instr  = buf_data_reg;
   assign mem_rd_en   = mem_rd_en_reg;
   assign mem_addr    = mem_addr_reg;

`ifdef FETCH_PREFETCH_EN
   logic [ADDR_WIDTH-1:0] pc_plus_one;
   // Natural wrap of the address width takes the last address back to 0.
   assign pc_plus_one = pc + ADDR_WIDTH'(1);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         buf_valid_reg <= 1'b0;
         buf_addr_reg  <= '0;
         buf_data_reg  <= '0;
         pend_addr_reg <= '0;
         mem_rd_en_reg <= 1'b0;
         mem_addr_reg  <= '0;
      end else begin
         mem_rd_en_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Read strobes arriving with nothing outstanding are dropped here.
               if (fetch_req && !hit) begin
                  mem_rd_en_reg <= 1'b1;
                  mem_addr_reg  <= pc;
                  pend_addr_reg <= pc;
                  state_reg     <= WAIT;
               end
`ifdef FETCH_PREFETCH_EN
               else if (instr_valid) begin
                  mem_rd_en_reg <= 1'b1;
                  mem_addr_reg  <= pc_plus_one;
                  pend_addr_reg <= pc_plus_one;
                  state_reg     <= WAIT;
               end
`endif
            end
            WAIT: begin
               // Returned data is buffered even if pc has moved on; the next
               // IDLE cycle re-evaluates the hit against the new address.
               if (mem_rd_valid) begin
                  buf_valid_reg <= 1'b1;
                  buf_addr_reg  <= pend_addr_reg;
                  buf_data_reg  <= mem_rd_data;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory responder with variable latency, a
// request driver pushing expected words, and a monitor checking every accepted instruction.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
   localparam int AW = 4;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] pc;
   logic          fetch_req;
   logic          instr_valid;
   logic [IW-1:0] next_instr;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_valid;
   logic [IW-1:0] mem_rd_data;

   always #5 clk = ~clk;

   instr_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
      .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req),
      .instr_valid(instr_valid), .next_instr(next_instr),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [IW-1:0] data;
   } exp_t;

   exp_t          sb_q[$];
   logic [IW-1:0] mem [0:15];
   int            checks = 0;
   int            errors = 0;

   // Memory responder controls and observations
   int            lat_cfg = 2;        // 0 = random latency 1..5
   bit            resp_ovr = 1'b0;    // return 8'hFF instead of memory contents
   bit            resp_busy = 1'b0;
   int            resp_cnt = 0;
   logic [AW-1:0] resp_addr = '0;
   logic [AW-1:0] resp_last_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Memory model: answers each read after its latency, flags overlapping requests.
   initial begin
      bit            req_now;
      bit            was_busy;
      logic [AW-1:0] req_addr;
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
      forever begin
         @(negedge clk);
         req_now  = (mem_rd_en === 1'b1);
         req_addr = mem_addr;
         was_busy = resp_busy;
         mem_rd_valid = 1'b0;
         if (req_now) begin
            checks++;
            if (was_busy) begin
               errors++;
               $display("FAIL single_outstanding: read of %0d issued while %0d pending, required none", req_addr, resp_addr);
            end
         end
         if (was_busy) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               mem_rd_valid   = 1'b1;
               mem_rd_data    = resp_ovr ? 8'hFF : mem[resp_addr];
               resp_last_addr = resp_addr;
               resp_busy      = 1'b0;
            end
         end
         if (req_now && !was_busy) begin
            resp_busy = 1'b1;
            resp_addr = req_addr;
            resp_cnt  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 5));
         end
      end
   end

   // Monitor: every accepted instruction must match the oldest expected word.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && instr_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_accept: pc %0d data %0h, required no accept", pc, next_instr);
            end else begin
               e = sb_q.pop_front();
               if (next_instr !== e.data || pc !== e.addr) begin
                  errors++;
                  $display("FAIL accept_data: pc %0d data %0h, required pc %0d data %0h",
                           pc, next_instr, e.addr, e.data);
               end
            end
         end
      end
   end

   // Request pc=p and hold it until accepted; returns at the accept cycle's falling edge.
   task automatic req_wait(input logic [AW-1:0] p, output int ncyc);
      sb_q.push_back('{p, mem[p]});
      @(posedge clk); #1;
      pc        = p;
      fetch_req = 1'b1;
      ncyc      = 0;
      @(negedge clk);
      while (instr_valid !== 1'b1 && ncyc < 60) begin
         ncyc++;
         @(negedge clk);
      end
      if (instr_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL fetch_timeout: pc %0d not accepted in %0d cycles, required accept", p, ncyc);
      end
   endtask

   // After an accept at p: a prefetch of p+1 follows in the next cycle, or nothing at all.
   task automatic post_accept(input logic [AW-1:0] p);
`ifndef FETCH_PREFETCH_EN
      int n;
`endif
      @(posedge clk); #1;
      fetch_req = 1'b0;
      @(negedge clk);
`ifdef FETCH_PREFETCH_EN
      check("prefetch_rd_en", 32'(mem_rd_en), 32'd1);
      check("prefetch_addr", 32'(mem_addr), 32'((int'(p) + 1) % 16));
      repeat (8) @(negedge clk);
`else
      n = 0;
      repeat (6) begin
         if (mem_rd_en === 1'b1) n++;
         @(negedge clk);
      end
      check("no_prefetch", 32'(n), 32'd0);
`endif
   endtask

   initial begin
      int            n;
      int            r;
      logic [AW-1:0] p;
`ifdef FETCH_PREFETCH_EN
      int            early;
      bit            saw7;
      bit            ret4;
`endif
      reset     = 1'b1;
      pc        = '0;
      fetch_req = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      repeat (3) @(negedge clk);
      check("reset_instr_valid", 32'(instr_valid), 32'd0);
      check("reset_next_instr", 32'(next_instr), 32'd0);
      check("reset_mem_rd_en", 32'(mem_rd_en), 32'd0);
      check("reset_mem_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;

      // Cold miss with memory latency 2
      sb_q.push_back('{4'd0, 8'hA5});
      @(posedge clk); #1;
      pc = 4'd0;
      fetch_req = 1'b1;
      @(negedge clk);
      check("cold_rd_en_c0", 32'(mem_rd_en), 32'd0);
      @(negedge clk);
      check("cold_rd_en_c1", 32'(mem_rd_en), 32'd1);
      check("cold_addr_c1", 32'(mem_addr), 32'd0);
      @(negedge clk);
      check("cold_valid_c2", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check("cold_valid_c3", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check("cold_valid_c4", 32'(instr_valid), 32'd1);
      check("cold_data_c4", 32'(next_instr), 32'hA5);
      post_accept(4'd0);

      // Zero-latency hit
`ifdef FETCH_PREFETCH_EN
      req_wait(4'd1, n);
      check("hit_latency", 32'(n), 32'd0);
      check("hit_data", 32'(next_instr), 32'h3C);
      post_accept(4'd1);
`else
      req_wait(4'd0, n);
      check("hit_latency", 32'(n), 32'd0);
      check("hit_data", 32'(next_instr), 32'hA5);
      post_accept(4'd0);
`endif

      req_wait(4'd2, n);
      post_accept(4'd2);
      req_wait(4'd15, n);
      post_accept(4'd15);

`ifdef FETCH_PREFETCH_EN
      // Redirect to 7 while the prefetch of 4 is outstanding
      lat_cfg = 4;
      req_wait(4'd3, n);
      sb_q.push_back('{4'd7, mem[7]});
      @(posedge clk); #1;
      pc = 4'd7;
      early = 0;
      saw7  = 1'b0;
      ret4  = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mem_rd_en === 1'b1 && mem_addr == 4'd7 && !saw7) begin
            saw7 = 1'b1;
            ret4 = (resp_last_addr == 4'd4) && !resp_busy;
         end
         if (instr_valid === 1'b1) begin
            if (!saw7) early++;
            break;
         end
      end
      check("redirect_no_early_valid", 32'(early), 32'd0);
      check("redirect_demand_read", 32'(saw7), 32'd1);
      check("redirect_after_prefetch", 32'(ret4), 32'd1);
      check("redirect_accepted", 32'(instr_valid), 32'd1);
      @(posedge clk); #1;
      fetch_req = 1'b0;
      repeat (10) @(negedge clk);
`endif

      // Reset while a read of 9 is outstanding; the late 8'hFF must be ignored
      lat_cfg = 4;
      resp_ovr = 1'b1;
      @(posedge clk); #1;
      pc = 4'd9;
      fetch_req = 1'b1;
      n = 0;
      @(negedge clk);
      while (mem_rd_en !== 1'b1 && n < 10) begin
         n++;
         @(negedge clk);
      end
      check("reset_test_read_issued", 32'(mem_rd_en), 32'd1);
      @(posedge clk); #1;
      fetch_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("late_data_next_instr", 32'(next_instr), 32'd0);
      check("late_data_instr_valid", 32'(instr_valid), 32'd0);
      resp_ovr = 1'b0;
      req_wait(4'd9, n);
      check("post_reset_miss_latency", 32'(n), 32'd6);

      // Randomized mix of sequential code and jumps
      lat_cfg = 0;
      p = 4'd9;
      repeat (150) begin
         r = int'($urandom_range(0, 9));
         if (r < 7) p = 4'((int'(p) + 1) % 16);
         else       p = 4'($urandom_range(0, 15));
         req_wait(p, n);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            fetch_req = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
         end
      end
      @(posedge clk); #1;
      fetch_req = 1'b0;
      repeat (10) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the CPU data path. Given the current `pc`, it reads 8-bit instructions from a latency-variable instruction memory over a single-outstanding read handshake. It holds the fetched instruction in a one-entry buffer and presents it on `next_instr` with a valid flag, so the controller asserts `ir_write` only when `instr_valid` is high. Optionally, it prefetches the sequential instruction `pc+1` after each accepted fetch.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: width of `pc` and `mem_addr`.
- `INSTR_WIDTH`, 8: width of an instruction word.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `pc`  input  ADDR_WIDTH: address of the instruction the controller wants.
- `fetch_req`  input  1: controller is in its fetch state and requests the instruction at `pc`.
- `instr_valid`  output  1: `next_instr` holds the instruction at `pc`.
- `next_instr`  output  INSTR_WIDTH: buffered instruction word; feeds the data-path instruction register.
- `mem_rd_en`  output  1: one-cycle read request to instruction memory.
- `mem_addr`  output  ADDR_WIDTH: read address; valid while `mem_rd_en` is high.
- `mem_rd_valid`  input  1: one-cycle strobe that returns read data.
- `mem_rd_data`  input  INSTR_WIDTH: read data; sampled only when `mem_rd_valid` is high.

## Operation
- Buffer state: `buf_valid`, `buf_addr`, `buf_data`. `next_instr` = `buf_data` at all times.
- Hit: `buf_valid && buf_addr == pc`.
  - `instr_valid = fetch_req && hit`, combinational from registers and inputs.
- Accept: a cycle with `instr_valid` high. The controller latches `next_instr` via `ir_write` in that same cycle.
- FSM states:
  - IDLE: no read outstanding.
    - `fetch_req && !hit`: issue a read of `pc` and go to WAIT.
    - Accept while prefetch is enabled: issue a read of `pc+1` and go to WAIT.
  - WAIT: exactly one read outstanding; `pend_addr` is registered.
    - On `mem_rd_valid`: `buf_data <= mem_rd_data`, `buf_addr <= pend_addr`, `buf_valid <= 1`, then return to IDLE.
- Issuing a read: `mem_rd_en` and `mem_addr` are registered and high for exactly one cycle, in the cycle after the decision.
- Only one read is ever outstanding. A `fetch_req` miss raised during WAIT is serviced only after the outstanding read returns; the miss is then re-evaluated against the newly buffered address.
- `pc+1` wraps modulo 2^ADDR_WIDTH (15 → 0).
- `mem_rd_valid` in IDLE (unsolicited or pre-reset) is ignored.
- Redirect (branch or jump): if `pc` changes while a prefetch is outstanding, the returned data is still buffered. It then misses against the new `pc`, and a demand read follows.

## Timing
- Reset values: `instr_valid`=0, `next_instr`=0, `mem_rd_en`=0, `mem_addr`=0, `buf_valid`=0, state IDLE.
- Hit latency is 0 cycles: `instr_valid` rises in the same cycle as `fetch_req`.
- Miss latency with memory latency L ≥ 1:
  - `fetch_req` in cycle 0.
  - `mem_rd_en` in cycle 1.
  - `mem_rd_valid` in cycle 1+L.
  - `instr_valid` in cycle 2+L.
- `mem_rd_valid` coinciding with an accept: legal, because a prefetch is only issued after an accept. The buffer is overwritten at that edge.
- `next_instr` is stable while `instr_valid` is high; the buffer is written only in WAIT.
- Reset mid-read: the state and buffer clear immediately. A late `mem_rd_valid` after reset lands in IDLE and is ignored.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - On accept, a read of `pc+1` is issued automatically.
  - Sequential code then hits with 0-cycle latency once the prefetch has returned.
- Not defined:
  - No read is issued on accept; every new `pc` is a miss.
  - A hit occurs only if the same `pc` is requested again.
  - Prefetch logic is removed from the RTL.

## Test plan
- Cold miss (prefetch off):
  - Stimulus: after reset, `pc`=0, `fetch_req`=1, memory L=2 returning 8'hA5.
  - Response: `mem_rd_en` with `mem_addr`=0 in cycle 1; `instr_valid`=1 and `next_instr`=8'hA5 in cycle 4.
- Prefetch hit (macro on):
  - Stimulus: accept at `pc`=0; memory returns 8'h3C.
  - Response: `mem_rd_en` with `mem_addr`=1 in the next cycle. After data 8'h3C returns, `pc`=1 with `fetch_req` gives `instr_valid`=1 in the same cycle and `next_instr`=8'h3C.
- Wrap-around:
  - Stimulus: accept at `pc`=15 (macro on).
  - Response: prefetch read with `mem_addr`=0.
- Redirect:
  - Stimulus: prefetch of address 4 outstanding; `pc` jumps to 7 with `fetch_req`.
  - Response: `instr_valid` stays 0. After the address-4 data returns, `mem_rd_en` fires with `mem_addr`=7, and `next_instr` equals the memory word at address 7.
- Reset mid-read:
  - Stimulus: assert `reset` during WAIT, then deliver `mem_rd_valid` with 8'hFF afterwards.
  - Response: `buf_valid` stays 0, `next_instr` stays 0, and there is no `instr_valid`.
- Macro off:
  - Stimulus: accept at `pc`=2.
  - Response: no `mem_rd_en` until the next miss.
